// File: rtl/ifetch_prefetch.sv
`default_nettype none
// ============================================================================
// Module   : ifetch_prefetch
// Brief    : Instruction prefetch queue feeding the datapath IF stage; drops
//            stale words on PC redirect. Define IFETCH_BYPASS_EN for the
//            same-cycle response-to-instr_out bypass.
// Revision : 1.0 - initial release
// ============================================================================
module ifetch_prefetch #(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_in,
    input  logic        stall_in,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_out,
    output logic        fetch_stall
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam int c_SUM_W = c_CNT_W + 2;
    localparam logic [c_SUM_W-1:0] c_DEPTH_SUM = c_SUM_W'(DEPTH);
    localparam logic [c_CNT_W-1:0] c_ONE       = c_CNT_W'(1);

    logic [31:0]        r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic [c_CNT_W-1:0] r_outstanding;
    logic [c_CNT_W-1:0] r_drop_cnt;
    logic [31:0]        r_base_addr;
    logic [31:0]        r_fetch_addr;

    logic               w_mismatch;
    logic               w_hit;
    logic [c_SUM_W-1:0] w_in_use;
    logic               w_drop_rsp;
    logic               w_rsp;
    logic               w_bypass;
    logic               w_byp_take;
    logic               w_push;
    logic               w_pop;
    logic               w_accept;

    assign w_mismatch = (pc_in != r_base_addr);
    assign w_hit      = !w_mismatch && (r_count != '0);
    assign w_in_use   = c_SUM_W'(r_count) + c_SUM_W'(r_outstanding) + c_SUM_W'(r_drop_cnt);

    // A response with nothing outstanding or dropping matches neither term and is ignored.
    assign w_drop_rsp = imem_rvalid && (r_drop_cnt != '0);
    assign w_rsp      = imem_rvalid && (r_drop_cnt == '0) && (r_outstanding != '0);

`ifdef IFETCH_BYPASS_EN
    assign w_bypass   = w_rsp && !w_mismatch && (r_count == '0);
`else
    assign w_bypass   = 1'b0;
`endif

    assign w_byp_take = w_bypass && !stall_in;
    assign w_push     = w_rsp && !w_mismatch && !w_byp_take;
    assign w_pop      = w_hit && !stall_in;

    assign imem_req   = !rst && !w_mismatch && (w_in_use < c_DEPTH_SUM);
    assign imem_addr  = r_fetch_addr;
    assign w_accept   = imem_req && imem_ready;

    assign instr_out   = w_hit ? r_mem[r_rd_ptr] : (w_bypass ? imem_rdata : NOP_INSTR);
    assign fetch_stall = !(w_hit || w_bypass);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_count       <= '0;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
            r_base_addr   <= '0;
            r_fetch_addr  <= '0;
        end else if (w_mismatch) begin
            // Everything in flight becomes stale; a response landing now is one of them.
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_count       <= '0;
            r_outstanding <= '0;
            r_drop_cnt    <= r_drop_cnt + r_outstanding - ((w_drop_rsp || w_rsp) ? c_ONE : '0);
            r_base_addr   <= pc_in;
            r_fetch_addr  <= pc_in;
        end else begin
            r_count       <= r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
            r_outstanding <= r_outstanding + c_CNT_W'(w_accept) - c_CNT_W'(w_rsp);
            r_drop_cnt    <= r_drop_cnt - c_CNT_W'(w_drop_rsp);
            if (w_accept) begin
                r_fetch_addr <= r_fetch_addr + 32'd4;
            end
            if (w_pop || w_byp_take) begin
                r_base_addr <= r_base_addr + 32'd4;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_mem[r_wr_ptr] <= imem_rdata;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ifetch_prefetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_ifetch_prefetch
// Brief    : Scoreboard bench for ifetch_prefetch with a latency/ready memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ifetch_prefetch;

    localparam int          c_DEPTH = 4;
    localparam logic [31:0] c_NOP   = 32'h0000_0013;
`ifdef IFETCH_BYPASS_EN
    localparam int          c_BYP   = 1;
`else
    localparam int          c_BYP   = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc_in = '0;
    logic        stall_in = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] instr_out;
    logic        fetch_stall;

    ifetch_prefetch #(.DEPTH(c_DEPTH), .NOP_INSTR(c_NOP)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .pc_in       (pc_in),
        .stall_in    (stall_in),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instr_out   (instr_out),
        .fetch_stall (fetch_stall)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int lat = 1;
    int gap = 0;
    int gap_cnt = 0;
    int due_q[$];
    logic [31:0] raddr_q[$];
    logic [31:0] sb_q[$];
    logic [31:0] next_pc = '0;
    logic        next_stall = 1'b0;
    logic        next_rst = 1'b1;
    logic [31:0] exp_fetch = '0;
    logic        redir_pend = 1'b0;
    int since_redir = 0;
    int redir_lat = -1;
    int n_acc = 0;
    int n_pop = 0;
    int n_stalled = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] word(input logic [31:0] a);
        if (a == 32'h0)      return 32'h0050_0093;
        else if (a == 32'h4) return 32'h0030_8113;
        else                 return a ^ 32'h5A5A_0003;
    endfunction

    task automatic redirect(input logic [31:0] a);
        next_pc = a;
        sb_q.delete();
        sb_q.push_back(word(a));
        redir_pend  = 1'b1;
        exp_fetch   = a;
        since_redir = 0;
        redir_lat   = -1;
        n_acc       = 0;
    endtask

    // One clock: drive after the rising edge, sample and score on the falling edge.
    task automatic cycle();
        @(posedge clk);
        #1;
        rst      = next_rst;
        pc_in    = next_pc;
        stall_in = next_stall;
        imem_ready = (gap_cnt == gap);
        gap_cnt  = (gap_cnt == gap) ? 0 : gap_cnt + 1;
        if (due_q.size() > 0 && due_q[0] <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = word(raddr_q[0]);
            void'(due_q.pop_front());
            void'(raddr_q.pop_front());
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'hDEAD_BEEF;
        end
        @(negedge clk);
        if (!rst) begin
            if (redir_pend) begin
                check("req_in_mismatch", {31'b0, imem_req}, 32'd0);
                redir_pend = 1'b0;
            end
            if (imem_req && imem_ready) begin
                check("imem_addr", imem_addr, exp_fetch);
                exp_fetch = exp_fetch + 32'd4;
                due_q.push_back(cyc + lat);
                raddr_q.push_back(imem_addr);
                n_acc++;
            end
            if (!fetch_stall) begin
                check("instr", instr_out, sb_q[0]);
                if (redir_lat < 0) redir_lat = since_redir;
                if (!stall_in) begin
                    void'(sb_q.pop_front());
                    next_pc = pc_in + 32'd4;
                    sb_q.push_back(word(next_pc));
                    n_pop++;
                end
            end else begin
                check("nop", instr_out, c_NOP);
                n_stalled++;
            end
            since_redir++;
        end
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        // Reset for two cycles
        next_rst = 1'b1;
        run(2);
        check("rst_req",   {31'b0, imem_req}, 32'd0);
        check("rst_addr",  imem_addr, 32'd0);
        check("rst_instr", instr_out, c_NOP);
        check("rst_stall", {31'b0, fetch_stall}, 32'd1);

        // Reset then fetch, L=1
        next_rst = 1'b0;
        next_pc  = '0;
        sb_q.push_back(word(32'h0));
        exp_fetch = '0; since_redir = 0; redir_lat = -1;
        run(4);
        check("first_hit_lat", redir_lat, 2 - c_BYP);
        n_stalled = 0;
        run(20);
        check("steady_stalls", n_stalled, 0);

        // Redirect at L=1: a response lands in the mismatch cycle
        redirect(32'h0000_0040);
        run(8);
        check("redir_lat_l1", redir_lat, 3 - c_BYP);

        // Slow memory: ready one cycle in four, L=2
        lat = 2; gap = 3; gap_cnt = 0; n_pop = 0;
        run(60);
        check("slow_progress", {31'b0, (n_pop >= 10)}, 32'd1);

        // Redirect with two responses in flight
        gap = 0; gap_cnt = 0;
        redirect(32'h0000_0008);
        run(12);
        redirect(32'h0000_0040);
        run(2);
        check("redir_one_req", n_acc, 1);
        run(10);
        check("redir_lat_l2", redir_lat, 4 - c_BYP);

        // Full queue under stall
        lat = 1;
        run(6);
        next_stall = 1'b1;
        redirect(32'h0000_0200);
        run(10);
        check("full_reqs", n_acc, c_DEPTH);
        check("full_req_low", {31'b0, imem_req}, 32'd0);
        next_stall = 1'b0; n_stalled = 0; n_pop = 0;
        run(c_DEPTH);
        check("drain_stalls", n_stalled, 0);
        check("drain_pops", n_pop, c_DEPTH);

        // Address wrap past 2^32
        redirect(32'hFFFF_FFF8);
        run(10);
        check("wrap_lat", redir_lat, 3 - c_BYP);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
